booth_mult_seq: RTL and testbench

- Parametrised, iterative radix-4 Booth multiplier; the next generation of the processor's multiply unit.
- Supports configurable operand width and a configurable number of Booth partial products summed per cycle (PP_PER_CYCLE), which trades area against latency.
- Per-operand signedness covers MUL, MULH, MULHSU and MULHU.
- Sits beside the ALU: the processor raises in_valid, is stalled via stall, and fetches product when out_valid pulses.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_r4_ppgen.sv | 30 +++
 rtl/booth_mult_seq.sv | 137 +++++++++++++
 tb/tb_booth_mult_seq.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, Booth group
// codes and the group/cycle count helpers used to size the datapath.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP,
        ST_DONE
    } state_t;

    localparam logic [2:0] BC_ZERO     = 3'b000;
    localparam logic [2:0] BC_POS1_LO  = 3'b001;
    localparam logic [2:0] BC_POS1_HI  = 3'b010;
    localparam logic [2:0] BC_POS2     = 3'b011;
    localparam logic [2:0] BC_NEG2     = 3'b100;
    localparam logic [2:0] BC_NEG1_LO  = 3'b101;
    localparam logic [2:0] BC_NEG1_HI  = 3'b110;
    localparam logic [2:0] BC_ZERO_ALT = 3'b111;

    // One extra group beyond WIDTH/2 absorbs the sign/zero extension of the multiplier.
    function automatic int booth_num_groups(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int booth_num_cycles(input int width, input int pp_per_cycle);
        return (booth_num_groups(width) + pp_per_cycle - 1) / pp_per_cycle;
    endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// Radix-4 Booth partial product generator: decodes one 3-bit group and returns
// the signed multiple of the extended multiplicand, already shifted by 2*group.
module booth_r4_ppgen
    import booth_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GIDX_W = 5
) (
    input  logic [2:0]         code,
    input  logic [2*WIDTH-1:0] mcand_ext,
    input  logic [GIDX_W-1:0]  group_idx,
    output logic [2*WIDTH-1:0] pp
);

    logic [2*WIDTH-1:0] base;

    always_comb begin
        base = '0;
        case (code)
            BC_ZERO, BC_ZERO_ALT:   base = '0;
            BC_POS1_LO, BC_POS1_HI: base = mcand_ext;
            BC_POS2:                base = mcand_ext << 1;
            BC_NEG2:                base = -(mcand_ext << 1);
            BC_NEG1_LO, BC_NEG1_HI: base = -mcand_ext;
            default:                base = '0;
        endcase
        pp = base << {group_idx, 1'b0};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: PP_PER_CYCLE groups are compressed into the
// accumulator each OP cycle; product is registered and flagged by out_valid.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    input  logic               mcand_signed,
    input  logic               mplier_signed,
    input  logic               flush,
    output logic [2*WIDTH-1:0] product,
    output logic               out_valid,
    output logic               stall
);

    localparam int NG   = booth_num_groups(WIDTH);
    localparam int NCYC = booth_num_cycles(WIDTH, PP_PER_CYCLE);
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int GW   = $clog2(NCYC * PP_PER_CYCLE + 1);
    localparam int PW   = 2 * WIDTH;

    localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);
    localparam logic [GW-1:0] NG_LIM   = GW'(NG);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH+2:0] mplier_q;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   pp [PP_PER_CYCLE];
    logic [PW-1:0]   cs_sum;
    logic [PW-1:0]   cs_carry;
    logic [PW-1:0]   t_sum;
    logic [PW-1:0]   t_carry;
    logic            accept;
    logic            last_cyc;

    assign accept   = (state == ST_IDLE) && in_valid && !flush;
    assign last_cyc = (cnt == CNT_LAST);

    // Groups past NG (ragged final cycle) are forced to a zero code.
    for (genvar p = 0; p < PP_PER_CYCLE; p++) begin : g_pp
        logic [GW-1:0] gidx;
        logic [GW-1:0] gsel;
        logic          in_range;
        logic [2:0]    code;

        assign gidx     = GW'(cnt) * GW'(PP_PER_CYCLE) + GW'(p);
        assign in_range = (gidx < NG_LIM);
        assign gsel     = in_range ? gidx : '0;
        assign code     = in_range ? mplier_q[{gsel, 1'b0} +: 3] : BC_ZERO;

        booth_r4_ppgen #(
            .WIDTH  (WIDTH),
            .GIDX_W (GW)
        ) u_ppgen (
            .code      (code),
            .mcand_ext (mcand_q),
            .group_idx (gsel),
            .pp        (pp[p])
        );
    end

    // Carry-save reduction of accumulator plus this cycle's partial products,
    // resolved by a single carry-propagate add.
    always_comb begin
        cs_sum   = acc;
        cs_carry = '0;
        t_sum    = '0;
        t_carry  = '0;
        for (int p = 0; p < PP_PER_CYCLE; p++) begin
            t_sum    = cs_sum ^ cs_carry ^ pp[p];
            t_carry  = ((cs_sum & cs_carry) | (cs_sum & pp[p]) | (cs_carry & pp[p])) << 1;
            cs_sum   = t_sum;
            cs_carry = t_carry;
        end
        acc_next = cs_sum + cs_carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_OP;
            ST_OP: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else if (last_cyc) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        out_valid = (state == ST_DONE);
        stall     = accept || (state == ST_OP);
    end

    // A flushed operation leaves product at its last completed value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc      <= '0;
            product  <= '0;
        end else if (accept) begin
            mcand_q  <= {{WIDTH{mcand_signed & mcand[WIDTH-1]}}, mcand};
            mplier_q <= {{2{mplier_signed & mplier[WIDTH-1]}}, mplier, 1'b0};
            acc      <= '0;
            cnt      <= '0;
        end else if (state == ST_OP && !flush) begin
            acc <= acc_next;
            if (last_cyc) begin
                product <= acc_next;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner cases on the default
// configuration plus random sweeps on three parameterisations against an arithmetic model.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Default configuration: WIDTH=32, PP_PER_CYCLE=4 -> 6 cycles to out_valid
    logic        d_in_valid, d_ms, d_ps, d_flush;
    logic [31:0] d_mcand, d_mplier;
    logic [63:0] d_product;
    logic        d_out_valid, d_stall;

    // WIDTH=16, PP_PER_CYCLE=9 -> 2 cycles to out_valid
    logic        h_in_valid, h_ms, h_ps, h_flush;
    logic [15:0] h_mcand, h_mplier;
    logic [31:0] h_product;
    logic        h_out_valid, h_stall;

    // WIDTH=32, PP_PER_CYCLE=1 -> 18 cycles to out_valid
    logic        s_in_valid, s_ms, s_ps, s_flush;
    logic [31:0] s_mcand, s_mplier;
    logic [63:0] s_product;
    logic        s_out_valid, s_stall;

    booth_mult_seq #(.WIDTH(32), .PP_PER_CYCLE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .mcand(d_mcand), .mplier(d_mplier),
        .mcand_signed(d_ms), .mplier_signed(d_ps), .flush(d_flush),
        .product(d_product), .out_valid(d_out_valid), .stall(d_stall)
    );

    booth_mult_seq #(.WIDTH(16), .PP_PER_CYCLE(9)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .mcand(h_mcand), .mplier(h_mplier),
        .mcand_signed(h_ms), .mplier_signed(h_ps), .flush(h_flush),
        .product(h_product), .out_valid(h_out_valid), .stall(h_stall)
    );

    booth_mult_seq #(.WIDTH(32), .PP_PER_CYCLE(1)) dut_pp1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .mcand(s_mcand), .mplier(s_mplier),
        .mcand_signed(s_ms), .mplier_signed(s_ps), .flush(s_flush),
        .product(s_product), .out_valid(s_out_valid), .stall(s_stall)
    );

    // Reference: extend each operand to the full product width, multiply, keep low bits.
    function automatic logic [63:0] ref_mul32(input logic [31:0] a, input logic [31:0] b,
                                              input logic sa, input logic sb);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'h0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] ref_mul16(input logic [15:0] a, input logic [15:0] b,
                                              input logic sa, input logic sb);
        logic [31:0] ea;
        logic [31:0] eb;
        ea = sa ? {{16{a[15]}}, a} : {16'h0, a};
        eb = sb ? {{16{b[15]}}, b} : {16'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return 32'($urandom());
        endcase
    endfunction

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0:       return 16'h0;
            1:       return 16'h1;
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the default DUT (must be IDLE) and wait, bounded, for out_valid.
    task automatic run_default(input logic [31:0] a, input logic [31:0] b,
                               input logic sa, input logic sb,
                               output logic [63:0] p, output int lat);
        d_mcand = a; d_mplier = b; d_ms = sa; d_ps = sb; d_in_valid = 1'b1;
        step();
        d_in_valid = 1'b0;
        lat = 1;
        while (d_out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        p = d_product;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        d_in_valid = 0; d_ms = 0; d_ps = 0; d_flush = 0; d_mcand = 0; d_mplier = 0;
        h_in_valid = 0; h_ms = 0; h_ps = 0; h_flush = 0; h_mcand = 0; h_mplier = 0;
        s_in_valid = 0; s_ms = 0; s_ps = 0; s_flush = 0; s_mcand = 0; s_mplier = 0;
        #12;
        checks++;
        if (d_product !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_product: got %h expected 0", d_product);
        end
        checks++;
        if (d_out_valid !== 1'b0 || d_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flags: got out_valid=%b stall=%b expected 0 0", d_out_valid, d_stall);
        end
        checks++;
        if (h_product !== 32'h0 || s_product !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_sweep_products: got %h %h expected 0 0", h_product, s_product);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        logic exp_valid;
        logic exp_stall;
        d_mcand = 32'd3; d_mplier = 32'd5; d_ms = 0; d_ps = 0; d_in_valid = 1'b1;
        #1;
        checks++;
        if (d_stall !== 1'b1) begin
            errors++; $display("[TB] FAIL accept_stall: got %b expected 1", d_stall);
        end
        step();
        d_in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp_valid = (k == 6);
            exp_stall = (k <= 5);
            checks++;
            if (d_out_valid !== exp_valid) begin
                errors++; $display("[TB] FAIL latency_out_valid cycle %0d: got %b expected %b", k, d_out_valid, exp_valid);
            end
            checks++;
            if (d_stall !== exp_stall) begin
                errors++; $display("[TB] FAIL latency_stall cycle %0d: got %b expected %b", k, d_stall, exp_stall);
            end
            if (k == 6) begin
                checks++;
                if (d_product !== 64'hF) begin
                    errors++; $display("[TB] FAIL product_3x5: got %h expected %h", d_product, 64'hF);
                end
            end
            step();
        end
    endtask

    task automatic test_corner_products();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vsa [4];
        logic        vsb [4];
        logic [63:0] vexp [4];
        logic [63:0] p;
        int          lat;
        va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        vsa = '{1'b0, 1'b1, 1'b1, 1'b1};
        vsb = '{1'b0, 1'b1, 1'b1, 1'b0};
        vexp = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_0000_0001};
        for (int i = 0; i < 4; i++) begin
            run_default(va[i], vb[i], vsa[i], vsb[i], p, lat);
            checks++;
            if (p !== vexp[i] || lat != 6) begin
                errors++; $display("[TB] FAIL corner_%0d: got %h after %0d cycles expected %h after 6", i, p, lat, vexp[i]);
            end
        end
    endtask

    task automatic test_ignore_in_valid();
        int   lat;
        logic seen;
        d_mcand = 32'd7; d_mplier = 32'd9; d_ms = 0; d_ps = 0; d_in_valid = 1'b1;
        step();
        d_in_valid = 1'b0;
        step();
        d_mcand = 32'h1234; d_mplier = 32'h10; d_ms = 1; d_ps = 1; d_in_valid = 1'b1;
        step();
        d_in_valid = 1'b0; d_mcand = 32'hDEAD_BEEF;
        lat = 3;
        while (d_out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        checks++;
        if (d_product !== 64'd63 || lat != 6) begin
            errors++; $display("[TB] FAIL ignore_in_valid: got %h after %0d cycles expected %h after 6", d_product, lat, 64'd63);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (d_out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("[TB] FAIL ignore_no_second_result: got out_valid=1 expected none");
        end
    endtask

    task automatic test_flush();
        logic        seen;
        logic [63:0] p;
        int          lat;
        d_mcand = 32'd11; d_mplier = 32'd13; d_ms = 0; d_ps = 0; d_in_valid = 1'b1;
        step();
        d_in_valid = 1'b0;
        step();
        step();
        d_flush = 1'b1;
        step();
        d_flush = 1'b0;
        checks++;
        if (d_out_valid !== 1'b0 || d_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_idle: got out_valid=%b stall=%b expected 0 0", d_out_valid, d_stall);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (d_out_valid === 1'b1) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0 || d_product !== 64'd63) begin
            errors++; $display("[TB] FAIL flush_hold: got out_valid_seen=%b product=%h expected 0 %h", seen, d_product, 64'd63);
        end
        run_default(32'd11, 32'd13, 1'b0, 1'b0, p, lat);
        checks++;
        if (p !== 64'd143 || lat != 6) begin
            errors++; $display("[TB] FAIL flush_recover: got %h after %0d cycles expected %h after 6", p, lat, 64'd143);
        end
    endtask

    task automatic test_async_reset();
        logic seen;
        d_mcand = 32'd5; d_mplier = 32'd5; d_ms = 0; d_ps = 0; d_in_valid = 1'b1;
        step();
        d_in_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (d_product !== 64'h0 || d_out_valid !== 1'b0 || d_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: got product=%h out_valid=%b stall=%b expected 0 0 0", d_product, d_out_valid, d_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (d_out_valid === 1'b1) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0 || d_product !== 64'h0) begin
            errors++; $display("[TB] FAIL async_reset_quiet: got out_valid_seen=%b product=%h expected 0 0", seen, d_product);
        end
    endtask

    task automatic test_random_default();
        logic [31:0] a, b;
        logic        sa, sb;
        logic [63:0] p, expv;
        int          lat;
        for (int i = 0; i < 300; i++) begin
            a = pick32(); b = pick32();
            sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            expv = ref_mul32(a, b, sa, sb);
            run_default(a, b, sa, sb, p, lat);
            checks++;
            if (p !== expv || lat != 6) begin
                errors++; $display("[TB] FAIL rand_default %h*%h s=%b%b: got %h after %0d cycles expected %h after 6", a, b, sa, sb, p, lat, expv);
            end
        end
    endtask

    task automatic test_sweep_w16();
        logic [15:0] a, b;
        logic        sa, sb;
        logic [31:0] expv;
        int          lat;
        for (int i = 0; i < 300; i++) begin
            a = pick16(); b = pick16();
            sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            expv = ref_mul16(a, b, sa, sb);
            h_mcand = a; h_mplier = b; h_ms = sa; h_ps = sb; h_in_valid = 1'b1;
            step();
            h_in_valid = 1'b0;
            lat = 1;
            while (h_out_valid !== 1'b1 && lat < 40) begin
                step();
                lat++;
            end
            checks++;
            if (h_product !== expv || lat != 2) begin
                errors++; $display("[TB] FAIL sweep_w16 %h*%h s=%b%b: got %h after %0d cycles expected %h after 2", a, b, sa, sb, h_product, lat, expv);
            end
            step();
        end
    endtask

    task automatic test_sweep_pp1();
        logic [31:0] a, b;
        logic        sa, sb;
        logic [63:0] expv;
        int          lat;
        for (int i = 0; i < 150; i++) begin
            a = pick32(); b = pick32();
            sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            expv = ref_mul32(a, b, sa, sb);
            s_mcand = a; s_mplier = b; s_ms = sa; s_ps = sb; s_in_valid = 1'b1;
            step();
            s_in_valid = 1'b0;
            lat = 1;
            while (s_out_valid !== 1'b1 && lat < 60) begin
                step();
                lat++;
            end
            checks++;
            if (s_product !== expv || lat != 18) begin
                errors++; $display("[TB] FAIL sweep_pp1 %h*%h s=%b%b: got %h after %0d cycles expected %h after 18", a, b, sa, sb, s_product, lat, expv);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corner_products();
        test_ignore_in_valid();
        test_flush();
        test_async_reset();
        test_random_default();
        test_sweep_w16();
        test_sweep_pp1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
